param_fetch_stage: RTL and testbench
====================================

# param_fetch_stage

Parameter fetch stage of the neuron datapath. For each of `numInputs` synapses, it reads a weight and an input index from their memories. It then reads the input value at `index + offset` and presents the `(neuronInput, neuronWeight)` pair to the downstream neuron/MAC stage with a ready/accept handshake. It runs once per reset, sits between the weight, index and input memories and the neuron accumulate stage, and drives all three memory address buses.

## Interface
- `DATA_W`, default 16: width of data, address, count and offset.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `readyNextParam` input 1: downstream accepts the presented pair when high while `paramsReady`=1.
- `numInputs` input 16: number of parameter pairs to fetch; unsigned; compared live.
- `offset` input 16: base added to the fetched index to form `inputAddr`.
- `weightVal` input 16: weight memory read data; 1-cycle synchronous read of `weightAddr`.
- `indexVal` input 16: index memory read data; 1-cycle synchronous read of `indexAddr`.
- `inputVal` input 16: input memory read data; 1-cycle synchronous read of `inputAddr`.
- `weightAddr` output 16: registered weight memory address (= parameter count).
- `indexAddr` output 16: registered index memory address (= parameter count).
- `inputAddr` output 16: registered input memory address.
- `neuronWeight` output 16: registered weight of the presented pair.
- `neuronInput` output 16: registered input of the presented pair.
- `paramsReady` output 1: the pair on `neuronInput`/`neuronWeight` is valid.

## Operation
- Internal state: 16-bit count `cnt`, weight holding register `wReg`, and the state register.
- States:
  - FETCH_WI: if `cnt >= numInputs` go to DONE, else go to CAP_WI. `weightAddr`/`indexAddr` already equal `cnt`.
  - CAP_WI: `wReg <= weightVal`, `inputAddr <= indexVal + offset` (mod 2^16, carry dropped), then go to FETCH_IN.
  - FETCH_IN: wait one cycle for the input memory read, then go to CAP_IN.
  - CAP_IN: `neuronInput <= inputVal`, `neuronWeight <= wReg`, `paramsReady <= 1`, then go to PRESENT.
  - PRESENT: hold while `readyNextParam`=0. When it is 1: `paramsReady <= 0`, `cnt <= cnt+1`, `weightAddr <= indexAddr <= cnt+1`, then go to FETCH_WI.
  - DONE: terminal; only `rst` leaves it. `paramsReady`=0 and all outputs hold.
- `neuronInput`/`neuronWeight` keep their last value after `paramsReady` falls; they change only in CAP_IN.
- `inputAddr` changes only in CAP_WI.
- `numInputs`=0: no memory reads and no `paramsReady` pulse; DONE one edge after reset.
- `numInputs` changed mid-run takes effect at the next FETCH_WI check.
- `cnt` never exceeds 0xFFFF because `numInputs` is 16-bit; no wrap is required.

## Timing
- Reset values:
  - state = FETCH_WI, `cnt`=0, `wReg`=0.
  - `weightAddr`=`indexAddr`=`inputAddr`=0.
  - `neuronInput`=`neuronWeight`=0, `paramsReady`=0.
- `rst` overrides everything, including mid-fetch and during PRESENT. The pair in flight is discarded.
- Edge numbering: E0 is the reset edge. With `readyNextParam`=1, each pair takes 5 edges.
  - Pair k: `paramsReady` rises at edge E(4+5k) and falls at E(5+5k).
  - `inputAddr` for pair k updates at E(2+5k).
  - `weightAddr`/`indexAddr` step to k+1 at E(5+5k).
- DONE is entered at E(1+5·numInputs).
- A stall in PRESENT extends only that pair. Outputs are stable throughout the stall.
- The handshake completes on the edge where `paramsReady`=1 and `readyNextParam`=1. Exactly one acceptance per pair.

## Structure
- Shared package:
  - `DATA_W` = 16.
  - State enum `{FETCH_WI, CAP_WI, FETCH_IN, CAP_IN, PRESENT, DONE}`.
- Single module. No sub-module is needed; the counter and address adder are inline.

## Test plan
- `numInputs`=3, `weightVal`=0xAAAA, `indexVal`=0xBBBB, `inputVal`=0xCCCC, `offset`=0xFFF0, `readyNextParam`=1, reset then 20 clocks:
  - `inputAddr`=0xBBAB after E2.
  - `paramsReady` high for one cycle after E4, E9 and E14, each time with `neuronInput`=0xCCCC and `neuronWeight`=0xAAAA.
  - `weightAddr`/`indexAddr` read 0, 1, 2, 3.
  - DONE from E16 with `paramsReady` staying 0.
- Reset values: check all outputs are 0 immediately after E0.
- `numInputs`=0: `paramsReady` never asserts; addresses stay 0.
- `readyNextParam`=0 during pair 0 for 3 cycles: `paramsReady` stays 1 and outputs hold; `weightAddr` stays 0 until the accept edge.
- `rst` asserted at E7 (mid pair 1): after reset, `cnt` restarts at 0 and `paramsReady` next rises at 4 edges after the reset edge.
- Address-dependent memory model (`weightVal`=0x1000+addr, `indexVal`=addr, `inputVal`=0x2000+addr, `offset`=0x10, `numInputs`=2): pairs are (0x2010, 0x1000) then (0x2011, 0x1001).

Source files
------------

// File: rtl/param_fetch_stage_pkg.sv
// Shared types for the neuron parameter fetch stage: data width and the
// fetch sequencer state encoding.
package param_fetch_stage_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        FETCH_WI,
        CAP_WI,
        FETCH_IN,
        CAP_IN,
        PRESENT,
        DONE
    } state_e;

endpackage

// File: rtl/param_fetch_stage.sv
// Parameter fetch stage: walks numInputs synapses, reads weight/index, then the
// indexed input, and presents each (input, weight) pair with a ready/accept handshake.
module param_fetch_stage #(
    parameter int DATA_W = param_fetch_stage_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              readyNextParam,
    input  logic [DATA_W-1:0] numInputs,
    input  logic [DATA_W-1:0] offset,
    input  logic [DATA_W-1:0] weightVal,
    input  logic [DATA_W-1:0] indexVal,
    input  logic [DATA_W-1:0] inputVal,
    output logic [DATA_W-1:0] weightAddr,
    output logic [DATA_W-1:0] indexAddr,
    output logic [DATA_W-1:0] inputAddr,
    output logic [DATA_W-1:0] neuronWeight,
    output logic [DATA_W-1:0] neuronInput,
    output logic              paramsReady
);

    import param_fetch_stage_pkg::*;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] w_reg_q, w_reg_d;
    logic [DATA_W-1:0] input_addr_q, input_addr_d;
    logic [DATA_W-1:0] neuron_input_q, neuron_input_d;
    logic [DATA_W-1:0] neuron_weight_q, neuron_weight_d;
    logic              params_ready_q, params_ready_d;

    // NOTE: every *_d starts from its *_q so no path through the case leaves a
    // variable unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        w_reg_d         = w_reg_q;
        input_addr_d    = input_addr_q;
        neuron_input_d  = neuron_input_q;
        neuron_weight_d = neuron_weight_q;
        params_ready_d  = params_ready_q;

        case (state_q)
            FETCH_WI: state_d = (cnt_q >= numInputs) ? DONE : CAP_WI;
            CAP_WI: begin
                w_reg_d      = weightVal;
                input_addr_d = indexVal + offset;
                state_d      = FETCH_IN;
            end
            FETCH_IN: state_d = CAP_IN;
            CAP_IN: begin
                neuron_input_d  = inputVal;
                neuron_weight_d = w_reg_q;
                params_ready_d  = 1'b1;
                state_d         = PRESENT;
            end
            PRESENT: begin
                if (readyNextParam) begin
                    params_ready_d = 1'b0;
                    cnt_d          = cnt_q + 1'b1;
                    state_d        = FETCH_WI;
                end
            end
            DONE:    params_ready_d = 1'b0;
            default: state_d = FETCH_WI;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= FETCH_WI;
            cnt_q           <= '0;
            w_reg_q         <= '0;
            input_addr_q    <= '0;
            neuron_input_q  <= '0;
            neuron_weight_q <= '0;
            params_ready_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            w_reg_q         <= w_reg_d;
            input_addr_q    <= input_addr_d;
            neuron_input_q  <= neuron_input_d;
            neuron_weight_q <= neuron_weight_d;
            params_ready_q  <= params_ready_d;
        end
    end

    // Weight and index memories share one address: the registered pair count.
    assign weightAddr   = cnt_q;
    assign indexAddr    = cnt_q;
    assign inputAddr    = input_addr_q;
    assign neuronInput  = neuron_input_q;
    assign neuronWeight = neuron_weight_q;
    assign paramsReady  = params_ready_q;

endmodule

// File: tb/tb_param_fetch_stage.sv
// Self-checking bench for param_fetch_stage: behavioural 1-cycle memories plus
// a scoreboard of expected (input, weight) pairs popped on each handshake.
module tb_param_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        readyNextParam = 1'b0;
    logic [15:0] numInputs = '0;
    logic [15:0] offset = '0;
    logic [15:0] weightVal;
    logic [15:0] indexVal;
    logic [15:0] inputVal;
    logic [15:0] weightAddr;
    logic [15:0] indexAddr;
    logic [15:0] inputAddr;
    logic [15:0] neuronWeight;
    logic [15:0] neuronInput;
    logic        paramsReady;

    int checks_total  = 0;
    int checks_passed = 0;
    int pairs_seen;
    logic mem_mode = 1'b0;  // 0: constant memory data, 1: address-dependent

    typedef struct packed {
        logic [15:0] inp;
        logic [15:0] wgt;
    } pair_t;
    pair_t exp_q[$];

    param_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .readyNextParam(readyNextParam),
        .numInputs     (numInputs),
        .offset        (offset),
        .weightVal     (weightVal),
        .indexVal      (indexVal),
        .inputVal      (inputVal),
        .weightAddr    (weightAddr),
        .indexAddr     (indexAddr),
        .inputAddr     (inputAddr),
        .neuronWeight  (neuronWeight),
        .neuronInput   (neuronInput),
        .paramsReady   (paramsReady)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory models.
    always @(posedge clk) begin
        weightVal <= mem_mode ? 16'h1000 + weightAddr : 16'hAAAA;
        indexVal  <= mem_mode ? indexAddr : 16'hBBBB;
        inputVal  <= mem_mode ? 16'h2000 + inputAddr : 16'hCCCC;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Applies the reset edge (E0) and leaves the bench sampling just after it.
    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        pairs_seen = 0;
    endtask

    // Compares a presented pair with the scoreboard head when an accept is pending.
    task automatic score(input string tag);
        pair_t e;
        if (paramsReady === 1'b1 && readyNextParam === 1'b1) begin
            checks_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL %s_unexpected_pair got in=%h w=%h required none", tag, neuronInput, neuronWeight);
            end else begin
                e = exp_q.pop_front();
                if (neuronInput !== e.inp || neuronWeight !== e.wgt)
                    $display("FAIL %s_pair got in=%h w=%h required in=%h w=%h", tag, neuronInput, neuronWeight, e.inp, e.wgt);
                else
                    checks_passed++;
            end
            pairs_seen++;
        end
    endtask

    task automatic test_reset();
        readyNextParam = 1'b1;
        numInputs = 16'd3;
        offset = 16'hFFF0;
        do_reset();
        checks_total++;
        if ({weightAddr, indexAddr, inputAddr, neuronInput, neuronWeight, paramsReady} !== '0)
            $display("FAIL reset_outputs got wa=%h ia=%h xa=%h in=%h w=%h rdy=%b required all 0",
                     weightAddr, indexAddr, inputAddr, neuronInput, neuronWeight, paramsReady);
        else
            checks_passed++;
    endtask

    task automatic test_basic();
        logic        exp_rdy;
        logic [15:0] exp_addr;
        mem_mode = 1'b0;
        readyNextParam = 1'b1;
        numInputs = 16'd3;
        offset = 16'hFFF0;
        do_reset();
        for (int k = 0; k < 3; k++) exp_q.push_back('{inp: 16'hCCCC, wgt: 16'hAAAA});
        for (int e = 1; e <= 20; e++) begin
            step();
            exp_rdy  = (e == 4 || e == 9 || e == 14);
            exp_addr = (e >= 15) ? 16'd3 : (e >= 10) ? 16'd2 : (e >= 5) ? 16'd1 : 16'd0;
            checks_total++;
            if (paramsReady !== exp_rdy)
                $display("FAIL basic_ready E%0d got %b required %b", e, paramsReady, exp_rdy);
            else
                checks_passed++;
            checks_total++;
            if (weightAddr !== exp_addr || indexAddr !== exp_addr)
                $display("FAIL basic_addr E%0d got wa=%h ia=%h required %h", e, weightAddr, indexAddr, exp_addr);
            else
                checks_passed++;
            if (e >= 2) begin
                checks_total++;
                if (inputAddr !== 16'hBBAB)
                    $display("FAIL basic_input_addr E%0d got %h required bbab", e, inputAddr);
                else
                    checks_passed++;
            end
            score("basic");
        end
        checks_total++;
        if (pairs_seen != 3 || exp_q.size() != 0)
            $display("FAIL basic_pair_count got %0d required 3", pairs_seen);
        else
            checks_passed++;
    endtask

    task automatic test_zero();
        int bad = 0;
        mem_mode = 1'b0;
        readyNextParam = 1'b1;
        numInputs = 16'd0;
        offset = 16'h0010;
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            step();
            if (paramsReady !== 1'b0 || weightAddr !== 16'd0 || inputAddr !== 16'd0) bad++;
        end
        checks_total++;
        if (bad != 0)
            $display("FAIL zero_inputs got %0d bad cycles (rdy=%b wa=%h xa=%h) required 0", bad, paramsReady, weightAddr, inputAddr);
        else
            checks_passed++;
    endtask

    task automatic test_stall();
        mem_mode = 1'b0;
        readyNextParam = 1'b0;
        numInputs = 16'd1;
        offset = 16'h0000;
        do_reset();
        exp_q.push_back('{inp: 16'hCCCC, wgt: 16'hAAAA});
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e >= 4) begin
                checks_total++;
                if (paramsReady !== 1'b1 || neuronInput !== 16'hCCCC || neuronWeight !== 16'hAAAA || weightAddr !== 16'd0)
                    $display("FAIL stall_hold E%0d got rdy=%b in=%h w=%h wa=%h required 1/cccc/aaaa/0",
                             e, paramsReady, neuronInput, neuronWeight, weightAddr);
                else
                    checks_passed++;
            end
        end
        readyNextParam = 1'b1;
        score("stall");
        for (int e = 8; e <= 12; e++) begin
            step();
            checks_total++;
            if (paramsReady !== 1'b0 || weightAddr !== 16'd1 || neuronInput !== 16'hCCCC)
                $display("FAIL stall_after E%0d got rdy=%b wa=%h in=%h required 0/1/cccc", e, paramsReady, weightAddr, neuronInput);
            else
                checks_passed++;
            score("stall_extra");
        end
        checks_total++;
        if (pairs_seen != 1)
            $display("FAIL stall_pair_count got %0d required 1", pairs_seen);
        else
            checks_passed++;
    endtask

    task automatic test_mid_reset();
        mem_mode = 1'b0;
        readyNextParam = 1'b1;
        numInputs = 16'd3;
        offset = 16'hFFF0;
        do_reset();
        for (int e = 1; e <= 6; e++) step();
        do_reset();
        checks_total++;
        if ({weightAddr, inputAddr, neuronInput, neuronWeight, paramsReady} !== '0)
            $display("FAIL midreset_clear got wa=%h xa=%h in=%h w=%h rdy=%b required all 0",
                     weightAddr, inputAddr, neuronInput, neuronWeight, paramsReady);
        else
            checks_passed++;
        exp_q.push_back('{inp: 16'hCCCC, wgt: 16'hAAAA});
        for (int e = 1; e <= 4; e++) begin
            step();
            checks_total++;
            if (paramsReady !== (e == 4))
                $display("FAIL midreset_ready E%0d got %b required %b", e, paramsReady, (e == 4));
            else
                checks_passed++;
            score("midreset");
        end
        checks_total++;
        if (pairs_seen != 1)
            $display("FAIL midreset_pair_count got %0d required 1", pairs_seen);
        else
            checks_passed++;
    endtask

    task automatic test_addr_model();
        logic [15:0] idx;
        mem_mode = 1'b1;
        readyNextParam = 1'b1;
        numInputs = 16'd2;
        offset = 16'h0010;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            idx = 16'(k);
            exp_q.push_back('{inp: 16'h2000 + idx + 16'h0010, wgt: 16'h1000 + idx});
        end
        for (int e = 1; e <= 14; e++) begin
            step();
            checks_total++;
            if (paramsReady !== (e == 4 || e == 9))
                $display("FAIL addr_ready E%0d got %b required %b", e, paramsReady, (e == 4 || e == 9));
            else
                checks_passed++;
            score("addr");
        end
        checks_total++;
        if (pairs_seen != 2 || exp_q.size() != 0 || weightAddr !== 16'd2 || inputAddr !== 16'h0011)
            $display("FAIL addr_final got pairs=%0d wa=%h xa=%h required 2/0002/0011", pairs_seen, weightAddr, inputAddr);
        else
            checks_passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_stall();
        test_mid_reset();
        test_addr_model();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
